// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: joystick/coin/DIP front end between hps_io and a game core (option: INPUT_ACTIVE_LOW_EN inverts dir/btn/coin outputs)
module arcade_input_mapper #(
   parameter int          NUM_PLAYERS = 2,
   parameter int          NUM_BUTTONS = 4,
   parameter int          NUM_COINS   = 2,
   parameter int          NUM_DSW     = 2,
   parameter logic [15:0] COIN_HOLD   = 16'd48000,
   parameter logic [7:0]  MODE_INDEX  = 8'd1
) (
   input  logic                               clk_sys,
   input  logic                               reset,
   input  logic                               ioctl_wr,
   input  logic [7:0]                         ioctl_index,
   input  logic [26:0]                        ioctl_addr,
   input  logic [15:0]                        ioctl_dout,
   input  logic [16*NUM_PLAYERS-1:0]          joy,
   input  logic [NUM_COINS-1:0]               coin_in,
   output logic [4*NUM_PLAYERS-1:0]           dir_out,
   output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_out,
   output logic [NUM_COINS-1:0]               coin_out,
   output logic [8*NUM_DSW-1:0]               dsw,
   output logic [7:0]                         mode
);
`ifdef INPUT_ACTIVE_LOW_EN
   localparam logic P_INV = 1'b1;
`else
   localparam logic P_INV = 1'b0;
`endif

   logic [4*NUM_PLAYERS-1:0]           r_dir;
   logic [NUM_BUTTONS*NUM_PLAYERS-1:0] r_btn;
   logic [NUM_COINS-1:0]               r_coin, r_act, r_coin_prev;
   logic [15:0]                        r_cnt [NUM_COINS];
   logic [3:0]                         r_prev [NUM_PLAYERS];
   logic [3:0]                         r_last [NUM_PLAYERS];
   logic [8*NUM_DSW-1:0]               r_dsw = '0;
   logic [7:0]                         r_mode = '0;
   logic [3:0]                         w_j [NUM_PLAYERS];
   logic [3:0]                         w_rise [NUM_PLAYERS];
   logic [3:0]                         w_hold [NUM_PLAYERS];
   logic [3:0]                         w_dir [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0]             w_unused_joy;
   logic                               w_unused;
   logic                               w_dsw_wr, w_mode_wr;

   // one-hot of the highest-priority held direction: up > down > left > right
   function automatic logic [3:0] prio(input logic [3:0] m);
      return m[3] ? 4'b1000 : m[2] ? 4'b0100 : m[1] ? 4'b0010 : m[0] ? 4'b0001 : 4'b0000;
   endfunction

   assign w_dsw_wr  = ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == '0;
   assign w_mode_wr = ioctl_wr && ioctl_index == MODE_INDEX;
   assign w_unused  = ^{ioctl_addr[26:25], ioctl_dout[15:8], w_unused_joy};

   // SOCD-neutral directions, 4-way selection and per-mode restriction
   always_comb begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         w_j[p]          = {(joy[16*p+3] & joy[16*p+2]) ? 2'b00 : joy[16*p+2 +: 2],
                            (joy[16*p+1] & joy[16*p])   ? 2'b00 : joy[16*p +: 2]};
         w_rise[p]       = w_j[p] & ~r_prev[p];
         w_hold[p]       = |(r_last[p] & w_j[p]) ? r_last[p] : prio(w_j[p]);
         w_dir[p]        = r_mode[1:0] == 2'd1 ? w_hold[p] :
                           r_mode[1:0] == 2'd2 ? (w_j[p] & 4'b0011) :
                           r_mode[1:0] == 2'd3 ? (w_j[p] & 4'b1100) : w_j[p];
         w_unused_joy[p] = ^joy[16*p+4+NUM_BUTTONS +: 12-NUM_BUTTONS];
      end
   end

   // download capture of DIP bytes and mode byte; deliberately untouched by reset
   always_ff @(posedge clk_sys) begin
      for (int k = 0; k < NUM_DSW; k++)
         if (w_dsw_wr && ioctl_addr[2:0] == 3'(k)) r_dsw[8*k +: 8] <= ioctl_dout[7:0];
      if (w_mode_wr) r_mode <= ioctl_dout[7:0];
   end

   // registered player outputs, 4-way history and coin stretchers
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_dir       <= {4*NUM_PLAYERS{P_INV}};
         r_btn       <= {NUM_BUTTONS*NUM_PLAYERS{P_INV}};
         r_coin      <= {NUM_COINS{P_INV}};
         r_act       <= '0;
         r_coin_prev <= '0;
         for (int c = 0; c < NUM_COINS; c++) r_cnt[c] <= '0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            r_prev[p] <= '0;
            r_last[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            r_dir[4*p +: 4]                     <= w_dir[p] ^ {4{P_INV}};
            r_btn[NUM_BUTTONS*p +: NUM_BUTTONS] <= joy[16*p+4 +: NUM_BUTTONS] ^ {NUM_BUTTONS{P_INV}};
            r_prev[p]                           <= w_j[p];
            r_last[p]                           <= w_mode_wr ? 4'b0000 : |w_rise[p] ? prio(w_rise[p]) : w_hold[p];
         end
         r_coin_prev <= coin_in;
         for (int c = 0; c < NUM_COINS; c++) begin
            if (r_act[c]) begin
               if (r_cnt[c] == '0) begin
                  r_act[c]  <= 1'b0;
                  r_coin[c] <= P_INV;
               end else begin
                  r_cnt[c] <= r_cnt[c] - 16'd1;
               end
            end else if (coin_in[c] && !r_coin_prev[c]) begin
               r_act[c]  <= 1'b1;
               r_coin[c] <= ~P_INV;
               r_cnt[c]  <= COIN_HOLD - 16'd1;
            end
         end
      end
   end

   assign dir_out  = r_dir;
   assign btn_out  = r_btn;
   assign coin_out = r_coin;
   assign dsw      = r_dsw;
   assign mode     = r_mode;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed stimulus checked against a cycle model and literal expectations
module tb_arcade_input_mapper;
   localparam int NP = 2, NB = 4, NC = 2, ND = 2, HOLD = 10;
`ifdef INPUT_ACTIVE_LOW_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif

   logic          clk_sys = 0, reset = 1, ioctl_wr = 0;
   logic [7:0]    ioctl_index = 0;
   logic [26:0]   ioctl_addr = 0;
   logic [15:0]   ioctl_dout = 0;
   logic [16*NP-1:0] joy = 0;
   logic [NC-1:0] coin_in = 0;
   logic [4*NP-1:0]  dir_out;
   logic [NB*NP-1:0] btn_out;
   logic [NC-1:0]    coin_out;
   logic [8*ND-1:0]  dsw;
   logic [7:0]       mode;

   int checks = 0, errors = 0;

   arcade_input_mapper #(.NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .NUM_COINS(NC), .NUM_DSW(ND),
                         .COIN_HOLD(16'(HOLD)), .MODE_INDEX(8'd1)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .joy(joy), .coin_in(coin_in),
      .dir_out(dir_out), .btn_out(btn_out), .coin_out(coin_out), .dsw(dsw), .mode(mode));

   always #5 clk_sys = ~clk_sys;

   // active-high views of the possibly inverted outputs
   wire [4*NP-1:0]  dir_h  = dir_out ^ {4*NP{INV}};
   wire [NB*NP-1:0] btn_h  = btn_out ^ {NB*NP{INV}};
   wire [NC-1:0]    coin_h = coin_out ^ {NC{INV}};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model: what the outputs must be after each clock edge
   logic [4*NP-1:0]  e_dir = 0;
   logic [NB*NP-1:0] e_btn = 0;
   logic [NC-1:0]    e_coin = 0, m_cprev = 0;
   logic [8*ND-1:0]  e_dsw = 0;
   logic [7:0]       e_mode = 0;
   logic [3:0]       m_prev [NP];
   int               m_last [NP];
   int               m_rem [NC];
   bit               started = 0;

   function automatic int top(input logic [3:0] m);
      for (int b = 3; b >= 0; b--) if (m[b]) return b;
      return -1;
   endfunction

   always @(posedge clk_sys) begin
      logic [3:0] j, fresh;
      int pick;
      if (reset) begin
         e_dir = 0; e_btn = 0; e_coin = 0; m_cprev = 0; started = 1;
         for (int p = 0; p < NP; p++) begin m_prev[p] = 0; m_last[p] = -1; end
         for (int c = 0; c < NC; c++) m_rem[c] = 0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            j = joy[16*p +: 4];
            if (j[0] && j[1]) j[1:0] = 2'b00;
            if (j[2] && j[3]) j[3:2] = 2'b00;
            pick = (m_last[p] >= 0 && j[m_last[p]]) ? m_last[p] : top(j);
            case (e_mode[1:0])
               2'd0: e_dir[4*p +: 4] = j;
               2'd1: e_dir[4*p +: 4] = pick < 0 ? 4'b0 : 4'(1 << pick);
               2'd2: e_dir[4*p +: 4] = {2'b00, j[1:0]};
               default: e_dir[4*p +: 4] = {j[3:2], 2'b00};
            endcase
            fresh = j & ~m_prev[p];
            m_last[p] = (ioctl_wr && ioctl_index == 8'd1) ? -1 : (fresh != 0 ? top(fresh) : pick);
            m_prev[p] = j;
            e_btn[NB*p +: NB] = joy[16*p+4 +: NB];
         end
         for (int c = 0; c < NC; c++) begin
            if (m_rem[c] > 0) m_rem[c]--;
            else if (coin_in[c] && !m_cprev[c]) m_rem[c] = HOLD;
            e_coin[c] = m_rem[c] > 0;
         end
         m_cprev = coin_in;
      end
      if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == 0 && ioctl_addr[2:0] < ND)
         e_dsw[8*ioctl_addr[2:0] +: 8] = ioctl_dout[7:0];
      if (ioctl_wr && ioctl_index == 8'd1) e_mode = ioctl_dout[7:0];
   end

   // compare process on the falling edge
   always @(negedge clk_sys) if (started) begin
      check("dir_out", 32'(dir_h), 32'(e_dir));
      check("btn_out", 32'(btn_h), 32'(e_btn));
      check("coin_out", 32'(coin_h), 32'(e_coin));
      check("dsw", 32'(dsw), 32'(e_dsw));
      check("mode", 32'(mode), 32'(e_mode));
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk_sys); #1; end
   endtask

   task automatic io(input logic [7:0] idx, input logic [26:0] addr, input logic [7:0] data);
      ioctl_wr = 1; ioctl_index = idx; ioctl_addr = addr; ioctl_dout = {8'h00, data};
      tick();
      ioctl_wr = 0;
   endtask

   // coin 0 pulse: held for hold cycles, optional extra 1-cycle pulse after tick re; counts high cycles
   task automatic coin_run(input int hold, input int re, input int n, output int cnt);
      cnt = 0;
      coin_in[0] = 1;
      for (int i = 0; i < n; i++) begin
         tick();
         cnt += int'(coin_h[0]);
         coin_in[0] = (i + 1 < hold) || (i == re);
      end
   endtask

   initial begin
      int cnt;
      tick(3);
      check("reset_dir", 32'(dir_out), 32'({4*NP{INV}}));
      check("reset_coin", 32'(coin_out), 32'({NC{INV}}));
      reset = 0;
      tick();
      io(8'd254, 27'd0, 8'hA5);
      io(8'd254, 27'd1, 8'h3C);
      io(8'd254, 27'd2, 8'hFF);
      io(8'd254, 27'd8, 8'h77);
      check("dsw_capture", 32'(dsw), 32'h3CA5);
      reset = 1; tick(); reset = 0; tick();
      check("dsw_after_reset", 32'(dsw), 32'h3CA5);
      io(8'd1, 27'd5, 8'h03);
      check("mode_capture", 32'(mode), 32'h03);
      io(8'd1, 27'd0, 8'h01);
      joy[3:0] = 4'b0001; joy[7:4] = 4'hA; joy[19:16] = 4'b0100;
      tick();
      check("4way_right", 32'(dir_h[3:0]), 32'b0001);
      check("btn_p0", 32'(btn_h[3:0]), 32'hA);
      tick(4);
      joy[3:0] = 4'b1001; tick();
      check("4way_up_lat", 32'(dir_h[3:0]), 32'b0001);
      tick();
      check("4way_up", 32'(dir_h[3:0]), 32'b1000);
      joy[3:0] = 4'b0001; tick();
      check("4way_release", 32'(dir_h[3:0]), 32'b0001);
      joy[3:0] = 4'b0000; tick(2);
      joy[3:0] = 4'b1010; tick();
      check("4way_simul", 32'(dir_h[3:0]), 32'b1000);
      joy[3:0] = 4'b0; tick(2);
      joy[3:0] = 4'b0100; tick(2);
      joy[3:0] = 4'b0110; tick(2);
      check("4way_keep_last", 32'(dir_h[3:0]), 32'b0010);
      io(8'd1, 27'd0, 8'h02);
      joy[3:0] = 4'b1001; tick(2);
      check("horiz", 32'(dir_h[3:0]), 32'b0001);
      io(8'd1, 27'd0, 8'h03); tick();
      check("vert", 32'(dir_h[3:0]), 32'b1000);
      io(8'd1, 27'd0, 8'h00);
      joy[3:0] = 4'b0011; tick(2);
      check("socd_lr", 32'(dir_h[3:0]), 32'b0000);
      joy[3:0] = 4'b0001; tick();
      check("pass", 32'(dir_h[3:0]), 32'b0001);
      joy = 0; tick(2);
      coin_run(1, -1, 20, cnt);
      check("coin_pulse", 32'(cnt), 32'd10);
      tick(2);
      coin_run(30, -1, 45, cnt);
      check("coin_held", 32'(cnt), 32'd10);
      tick(2);
      coin_run(1, 4, 30, cnt);
      check("coin_reedge", 32'(cnt), 32'd10);
      tick(2);
      coin_in[0] = 1; tick(); coin_in[0] = 0; tick(3);
      reset = 1; tick();
      check("coin_reset", 32'(coin_h[0]), 32'd0);
      reset = 0; tick();
      coin_run(1, -1, 20, cnt);
      check("coin_after_reset", 32'(cnt), 32'd10);
      coin_in[1] = 1; tick(); coin_in[1] = 0; tick(3);
      check("coin1", 32'(coin_h), 32'b10);
      tick(10);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised player-input front end between hps_io and a game core; generalises the fixed per-game joystick/coin/DIP packing in the emu top level.
- Latches DIP bytes and a per-title mode byte from the ioctl download stream.
- Applies a selectable joystick restriction per player (8-way, 4-way last-pressed, horizontal-only, vertical-only) and stretches coin pulses.
- All outputs are registered, and are active-high by default.

Parameters:
- NUM_PLAYERS, 2, number of joystick inputs and filtered direction outputs (1-4).
- NUM_BUTTONS, 4, buttons per player, taken from joy bits [4 +: NUM_BUTTONS] (1-8).
- NUM_COINS, 2, coin inputs handled by the stretcher (1-4).
- NUM_DSW, 2, DIP bytes captured from ioctl index 254 (1-8).
- COIN_HOLD, 16'd48000, clk_sys cycles a coin output stays asserted per insertion.
- MODE_INDEX, 8'd1, ioctl_index whose data byte is latched as the mode byte.

Ports:
- clk_sys, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- ioctl_wr, in, 1, download write strobe.
- ioctl_index, in, 8, download index.
- ioctl_addr, in, 27, download byte address.
- ioctl_dout, in, 16, download data; only [7:0] is used.
- joy, in, 16*NUM_PLAYERS, hps_io joysticks; per player [0]=right, [1]=left, [2]=down, [3]=up, [4+]=buttons.
- coin_in, in, NUM_COINS, raw coin buttons.
- dir_out, out, 4*NUM_PLAYERS, filtered directions per player, same bit order as joy[3:0].
- btn_out, out, NUM_BUTTONS*NUM_PLAYERS, registered buttons.
- coin_out, out, NUM_COINS, stretched coin pulses.
- dsw, out, 8*NUM_DSW, captured DIP bytes; byte k = dsw[8k +: 8].
- mode, out, 8, latched mode byte; bits [1:0] = joystick mode, shared by all players.

Behaviour:
- Clock and reset:
  - Single clock domain, clk_sys.
  - reset is synchronous and active-high.
- Reset values:
  - dir_out, btn_out and coin_out are 0.
  - Coin counters and edge history are cleared.
  - Per-player 4-way state last = NONE.
  - dsw and mode are NOT affected by reset; their power-up value is 0. They are written only by ioctl.
- DIP capture:
  - Write when ioctl_wr && ioctl_index==254 && ioctl_addr[24:3]==0 && ioctl_addr[2:0]<NUM_DSW: dsw byte[ioctl_addr[2:0]] <= ioctl_dout[7:0].
  - Addresses >= NUM_DSW are ignored.
  - Update appears the cycle after the strobe.
- Mode capture:
  - ioctl_wr && ioctl_index==MODE_INDEX: mode <= ioctl_dout[7:0].
  - Last write wins. Address is ignored.
- Latency: joy and coin_in to outputs is 1 clk_sys cycle (registered). Exception: 4-way mode (see below).
- Joystick modes (mode[1:0]):
  - 0 = pass-through: dir_out = joy[3:0].
  - 1 = 4-way, last-pressed wins:
    - On a rising edge of a direction, last <= that direction.
    - Output is only that direction while it is held.
    - If last is released, or last=NONE, pick from held directions by priority up > down > left > right.
    - Simultaneous new presses resolve by the same priority.
    - None held -> last=NONE, output 0.
    - Edge detection uses a registered copy of joy, so there is one extra cycle of latency on a change of last.
  - 2 = horizontal only: {up,down} forced 0.
  - 3 = vertical only: {left,right} forced 0.
  - Opposite directions held together (right+left, or up+down) are both forced to 0 in every mode (SOCD neutral). This is applied before the mode logic.
  - A mode change takes effect the next cycle; last is cleared to NONE on any mode write.
- Coin stretcher (per coin):
  - Rising edge of coin_in while idle loads the counter with COIN_HOLD-1 and asserts coin_out.
  - coin_out stays high until the counter reaches 0, i.e. exactly COIN_HOLD cycles.
  - Edges during hold are ignored.
  - Re-trigger needs coin_in low then high again after the hold ends. A button held through the hold does not re-trigger.
  - Counter width is 16 bits.
- Reset mid-operation: an active hold aborts, and coin_out is 0 the next cycle.

Optional Feature:
- Macro: INPUT_ACTIVE_LOW_EN.
- Defined: dir_out, btn_out and coin_out are inverted at the output register. Their reset value is all ones.
- Undefined: active-high as described above.
- dsw and mode are never inverted.

Test Plan:
- DIP/mode capture:
  - Stimulus: ioctl_index=254, addr=0 data=8'hA5; addr=1 data=8'h3C; addr=2 data=8'hFF (NUM_DSW=2); then pulse reset.
  - Required: dsw=16'h3CA5, byte 2 ignored, and dsw unchanged after reset.
  - Stimulus: index=1 data=8'h03.
  - Required: mode=8'h03.
- 4-way last-pressed (mode=1):
  - Hold right, then add up 5 cycles later.
  - Required: dir_out goes 4'b0001, then 4'b1000 (one extra cycle of latency).
  - Release up. Required: 4'b0001.
  - Press up and left in the same cycle. Required: 4'b1000.
- Axis restriction:
  - mode=2 with joy[3:0]=4'b1001. Required: dir_out=4'b0001.
  - mode=3 with joy[3:0]=4'b1001. Required: dir_out=4'b1000.
  - Any mode with joy[3:0]=4'b0011. Required: 4'b0000.
- Coin stretch (COIN_HOLD=10):
  - 1-cycle coin_in pulse. Required: coin_out high exactly 10 cycles.
  - coin_in held 30 cycles. Required: one 10-cycle pulse only.
  - Second edge at cycle 5 of the hold. Required: ignored.
- Reset mid-hold: assert reset at hold cycle 4. Required: coin_out=0 the next cycle and the counter cleared; a new edge after reset gives a full 10-cycle pulse.
- INPUT_ACTIVE_LOW_EN build:
  - Required: after reset dir_out=all ones.
  - Pass-through with joy[3:0]=4'b0001. Required: dir_out=4'b1110.
